// File: rtl/instr_fetch_unit_if.sv
// Fetch-unit bus bundle: control, program-load port and fetched-instruction outputs.
// Latency: none; this is wiring only.
// Backpressure: hold is the only stall; the consumer asserts it to freeze the fetch stream.
interface instr_fetch_unit_if #(
   parameter int INSTR_W = 20,
   parameter int ADDR_W  = 5
);
   logic               start;
   logic               hold;
   logic               jump_valid;
   logic [ADDR_W-1:0]  jump_target;
   logic               prog_we;
   logic [ADDR_W-1:0]  prog_addr;
   logic [INSTR_W-1:0] prog_data;
   logic [INSTR_W-1:0] instruction;
   logic [ADDR_W-1:0]  instr_pc;
   logic               instr_valid;
   logic               halted;

   // Requester side: drives control and program-load, consumes instructions.
   modport master (
      output start, hold, jump_valid, jump_target, prog_we, prog_addr, prog_data,
      input  instruction, instr_pc, instr_valid, halted
   );

   // Fetch unit side.
   modport slave (
      input  start, hold, jump_valid, jump_target, prog_we, prog_addr, prog_data,
      output instruction, instr_pc, instr_valid, halted
   );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: writable program memory, pc with jump/halt, registered instruction out.
// Latency: start sampled at E0 -> mem[0] valid after E1; one instruction per unstalled cycle.
// Backpressure: hold freezes pc, state and all outputs; pending jumps wait until hold drops.
module instr_fetch_unit #(
   parameter int INSTR_W   = 20,
   parameter int ADDR_W    = 5,
   parameter int LAST_ADDR = 24
) (
   input  logic              clk,
   input  logic              reset,
   instr_fetch_unit_if.slave bus
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_HALT = 2'd2
   } state_t;

   localparam logic [ADDR_W-1:0] LP_LAST = ADDR_W'(LAST_ADDR);
   localparam int                LP_DEPTH = 2 ** ADDR_W;

   // Program store; deliberately not touched by reset so a loaded program survives it.
   logic [INSTR_W-1:0] r_mem [LP_DEPTH];

   state_t             r_state, w_state_nxt;
   logic [ADDR_W-1:0]  r_pc, w_pc_nxt;
   logic [INSTR_W-1:0] r_instr, w_instr_nxt;
   logic [ADDR_W-1:0]  r_instr_pc, w_instr_pc_nxt;
   logic               r_instr_vld, w_instr_vld_nxt;
   logic               w_mem_we;

   // Loading is only allowed while no program is executing; reset blocks it as well.
   assign w_mem_we = bus.prog_we && !reset && (r_state != S_RUN);

   // Program memory write port.
   always_ff @(posedge clk) begin
      if (w_mem_we) begin
         r_mem[bus.prog_addr] <= bus.prog_data;
      end
   end

   // Control and output registers, synchronous reset back to IDLE.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= S_IDLE;
         r_pc        <= '0;
         r_instr     <= '0;
         r_instr_pc  <= '0;
         r_instr_vld <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_pc        <= w_pc_nxt;
         r_instr     <= w_instr_nxt;
         r_instr_pc  <= w_instr_pc_nxt;
         r_instr_vld <= w_instr_vld_nxt;
      end
   end

   // Next-state logic: start/run/halt sequencing, hold freeze, jump squash, sequential fetch.
   always_comb begin
      w_state_nxt     = r_state;
      w_pc_nxt        = r_pc;
      w_instr_nxt     = r_instr;
      w_instr_pc_nxt  = r_instr_pc;
      w_instr_vld_nxt = r_instr_vld;

      case (r_state)
         S_RUN: begin
            if (!bus.hold) begin
               if (bus.jump_valid) begin
                  // Squashed slot: no fetch, hence no halt even if pc sits on the last address.
                  w_pc_nxt        = bus.jump_target;
                  w_instr_vld_nxt = 1'b0;
               end else begin
                  w_instr_nxt     = r_mem[r_pc];
                  w_instr_pc_nxt  = r_pc;
                  w_instr_vld_nxt = 1'b1;
                  if (r_pc == LP_LAST) begin
                     w_state_nxt = S_HALT;
                  end else begin
                     w_pc_nxt = r_pc + ADDR_W'(1);
                  end
               end
            end
         end
         default: begin
            // IDLE and HALT: nothing new is presented; last fetched values stay visible.
            w_instr_vld_nxt = 1'b0;
            if (bus.start) begin
               w_state_nxt = S_RUN;
               w_pc_nxt    = '0;
            end
         end
      endcase
   end

   assign bus.instruction = r_instr;
   assign bus.instr_pc    = r_instr_pc;
   assign bus.instr_valid = r_instr_vld;
   assign bus.halted      = (r_state == S_HALT);

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed scenarios plus randomized run vs reference.
// Latency: checks sample outputs 1 time unit after each rising edge.
// Backpressure: hold/jump stimulus is driven by the bench and modelled in the reference.
module tb_instr_fetch_unit;
   localparam int IW    = 20;
   localparam int AW    = 5;
   localparam int LAST  = 24;
   localparam int AWB   = 3;
   localparam int LASTB = 2;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   instr_fetch_unit_if #(.INSTR_W(IW), .ADDR_W(AW))  ifa ();
   instr_fetch_unit_if #(.INSTR_W(IW), .ADDR_W(AWB)) ifb ();

   instr_fetch_unit #(.INSTR_W(IW), .ADDR_W(AW), .LAST_ADDR(LAST)) dut_a (
      .clk(clk), .reset(reset), .bus(ifa.slave));
   instr_fetch_unit #(.INSTR_W(IW), .ADDR_W(AWB), .LAST_ADDR(LASTB)) dut_b (
      .clk(clk), .reset(reset), .bus(ifb.slave));

   wire [IW+AW+1:0]  obs_a = {ifa.instruction, ifa.instr_pc, ifa.instr_valid, ifa.halted};
   wire [IW+AWB+1:0] obs_b = {ifb.instruction, ifb.instr_pc, ifb.instr_valid, ifb.halted};

   int n_checks = 0;
   int n_fail   = 0;
   logic [IW-1:0] mem_a [32];
   logic [IW-1:0] mem_b [8];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      ifa.start = 0; ifa.hold = 0; ifa.jump_valid = 0; ifa.jump_target = '0;
      ifa.prog_we = 0; ifa.prog_addr = '0; ifa.prog_data = '0;
      ifb.start = 0; ifb.hold = 0; ifb.jump_valid = 0; ifb.jump_target = '0;
      ifb.prog_we = 0; ifb.prog_addr = '0; ifb.prog_data = '0;
   endtask

   // Only called while DUT A is idle or halted, so the write must land.
   task automatic write_a(input int addr, input logic [IW-1:0] d);
      ifa.prog_we = 1; ifa.prog_addr = AW'(addr); ifa.prog_data = d;
      tick();
      ifa.prog_we = 0;
      mem_a[addr] = d;
   endtask

   task automatic pulse_start_a();
      ifa.start = 1;
      tick();
      ifa.start = 0;
   endtask

   task automatic test_reset();
      logic [IW+AW+1:0]  exp;
      logic [IW+AWB+1:0] expb;
      reset = 1;
      idle_inputs();
      tick(); tick();
      exp = '0; expb = '0;
      n_checks++;
      if (obs_a !== exp) begin n_fail++; $display("FAIL reset_a: got %h expected %h", obs_a, exp); end
      n_checks++;
      if (obs_b !== expb) begin n_fail++; $display("FAIL reset_b: got %h expected %h", obs_b, expb); end
      reset = 0;
      tick();
      n_checks++;
      if (obs_a !== exp) begin n_fail++; $display("FAIL idle_a: got %h expected %h", obs_a, exp); end
   endtask

   task automatic test_sequential();
      logic [IW+AW+1:0] exp;
      for (int k = 0; k < 32; k++) write_a(k, (k <= LAST) ? IW'(k + 100) : IW'($urandom));
      pulse_start_a();
      exp = '0;
      n_checks++;
      if (obs_a !== exp) begin n_fail++; $display("FAIL seq_start_bubble: got %h expected %h", obs_a, exp); end
      for (int i = 0; i <= LAST; i++) begin
         tick();
         exp = {mem_a[i], AW'(i), 1'b1, (i == LAST)};
         n_checks++;
         if (obs_a !== exp) begin n_fail++; $display("FAIL seq[%0d]: got %h expected %h", i, obs_a, exp); end
      end
      for (int j = 0; j < 2; j++) begin
         tick();
         exp = {mem_a[LAST], AW'(LAST), 1'b0, 1'b1};
         n_checks++;
         if (obs_a !== exp) begin n_fail++; $display("FAIL seq_halt[%0d]: got %h expected %h", j, obs_a, exp); end
      end
   endtask

   task automatic test_hold();
      logic [IW+AW+1:0] exp;
      pulse_start_a();
      for (int i = 0; i <= 5; i++) tick();
      ifa.hold = 1;
      for (int j = 0; j < 3; j++) begin
         tick();
         exp = {mem_a[5], AW'(5), 1'b1, 1'b0};
         n_checks++;
         if (obs_a !== exp) begin n_fail++; $display("FAIL hold[%0d]: got %h expected %h", j, obs_a, exp); end
      end
      ifa.hold = 0;
      for (int i = 6; i <= LAST; i++) begin
         tick();
         exp = {mem_a[i], AW'(i), 1'b1, (i == LAST)};
         n_checks++;
         if (obs_a !== exp) begin n_fail++; $display("FAIL hold_resume[%0d]: got %h expected %h", i, obs_a, exp); end
      end
      tick();
   endtask

   task automatic test_jump();
      logic [IW+AW+1:0] exp;
      pulse_start_a();
      for (int i = 0; i <= 7; i++) tick();
      ifa.jump_valid = 1; ifa.jump_target = AW'(20);
      tick();
      ifa.jump_valid = 0;
      exp = {mem_a[7], AW'(7), 1'b0, 1'b0};
      n_checks++;
      if (obs_a !== exp) begin n_fail++; $display("FAIL jump_bubble: got %h expected %h", obs_a, exp); end
      for (int i = 20; i <= LAST; i++) begin
         tick();
         exp = {mem_a[i], AW'(i), 1'b1, (i == LAST)};
         n_checks++;
         if (obs_a !== exp) begin n_fail++; $display("FAIL jump_seq[%0d]: got %h expected %h", i, obs_a, exp); end
      end
      tick();
      // A jump squashing the slot at the last address must not halt.
      pulse_start_a();
      ifa.jump_valid = 1; ifa.jump_target = AW'(LAST);
      tick();
      ifa.jump_target = AW'(22);
      tick();
      ifa.jump_valid = 0;
      exp = {mem_a[LAST], AW'(LAST), 1'b0, 1'b0};
      n_checks++;
      if (obs_a !== exp) begin n_fail++; $display("FAIL jump_squash_last: got %h expected %h", obs_a, exp); end
      for (int i = 22; i <= LAST; i++) begin
         tick();
         exp = {mem_a[i], AW'(i), 1'b1, (i == LAST)};
         n_checks++;
         if (obs_a !== exp) begin n_fail++; $display("FAIL jump_squash_seq[%0d]: got %h expected %h", i, obs_a, exp); end
      end
      tick();
   endtask

   task automatic test_prog_we();
      logic [IW+AW+1:0] exp;
      pulse_start_a();
      for (int i = 0; i <= LAST; i++) begin
         ifa.prog_we = (i < 6); ifa.prog_addr = AW'(3); ifa.prog_data = IW'('hABCDE);
         tick();
         exp = {mem_a[i], AW'(i), 1'b1, (i == LAST)};
         n_checks++;
         if (obs_a !== exp) begin n_fail++; $display("FAIL we_in_run[%0d]: got %h expected %h", i, obs_a, exp); end
      end
      ifa.prog_we = 0;
      tick();
      write_a(3, IW'('hABCDE));
      // Write and start in the same cycle: first fetch must see the new word.
      ifa.prog_we = 1; ifa.prog_addr = '0; ifa.prog_data = IW'('h5A5A5); ifa.start = 1;
      tick();
      mem_a[0] = IW'('h5A5A5);
      ifa.prog_we = 0; ifa.start = 0;
      for (int i = 0; i <= LAST; i++) begin
         tick();
         exp = {mem_a[i], AW'(i), 1'b1, (i == LAST)};
         n_checks++;
         if (obs_a !== exp) begin n_fail++; $display("FAIL we_in_halt[%0d]: got %h expected %h", i, obs_a, exp); end
      end
      tick();
      write_a(0, IW'(100));
      write_a(3, IW'(103));
   endtask

   task automatic test_reset_midrun();
      logic [IW+AW+1:0] exp;
      pulse_start_a();
      for (int i = 0; i <= 11; i++) tick();
      reset = 1;
      tick();
      reset = 0;
      exp = '0;
      n_checks++;
      if (obs_a !== exp) begin n_fail++; $display("FAIL midrun_reset: got %h expected %h", obs_a, exp); end
      ifa.start = 0;
      tick();
      n_checks++;
      if (obs_a !== exp) begin n_fail++; $display("FAIL after_reset_idle: got %h expected %h", obs_a, exp); end
      pulse_start_a();
      for (int i = 0; i <= LAST; i++) begin
         tick();
         exp = {mem_a[i], AW'(i), 1'b1, (i == LAST)};
         n_checks++;
         if (obs_a !== exp) begin n_fail++; $display("FAIL replay[%0d]: got %h expected %h", i, obs_a, exp); end
      end
      tick();
   endtask

   task automatic test_wrap();
      logic [IW+AWB+1:0] exp;
      int seq [5] = '{6, 7, 0, 1, 2};
      for (int k = 0; k < 8; k++) begin
         mem_b[k] = IW'($urandom);
         ifb.prog_we = 1; ifb.prog_addr = AWB'(k); ifb.prog_data = mem_b[k];
         tick();
      end
      ifb.prog_we = 0;
      ifb.start = 1;
      tick();
      ifb.start = 0;
      ifb.jump_valid = 1; ifb.jump_target = AWB'(6);
      tick();
      ifb.jump_valid = 0;
      n_checks++;
      if (obs_b[1:0] !== 2'b00) begin n_fail++; $display("FAIL wrap_bubble: got %b expected 00", obs_b[1:0]); end
      for (int i = 0; i < 5; i++) begin
         tick();
         exp = {mem_b[seq[i]], AWB'(seq[i]), 1'b1, (i == 4)};
         n_checks++;
         if (obs_b !== exp) begin n_fail++; $display("FAIL wrap[%0d]: got %h expected %h", i, obs_b, exp); end
      end
      tick();
      exp = {mem_b[LASTB], AWB'(LASTB), 1'b0, 1'b1};
      n_checks++;
      if (obs_b !== exp) begin n_fail++; $display("FAIL wrap_halt: got %h expected %h", obs_b, exp); end
   endtask

   // Reference: a run fetches addresses in order (mod 32), redirected by jumps, until LAST is fetched.
   task automatic test_random();
      logic [IW+AW+1:0] exp;
      bit running = 0;
      int next_addr = 0;
      logic [IW-1:0] m_instr = '0;
      int m_ipc = 0;
      bit m_vld = 0, m_halt = 0;
      reset = 1;
      tick();
      reset = 0;
      for (int c = 0; c < 600; c++) begin
         ifa.start       = ($urandom_range(0, 7) == 0);
         ifa.hold        = ($urandom_range(0, 3) == 0);
         ifa.jump_valid  = ($urandom_range(0, 9) == 0);
         ifa.jump_target = AW'($urandom_range(0, 31));
         ifa.prog_we     = ($urandom_range(0, 4) == 0);
         ifa.prog_addr   = AW'($urandom_range(0, 31));
         ifa.prog_data   = IW'($urandom);
         if (!running) begin
            if (ifa.prog_we) mem_a[ifa.prog_addr] = ifa.prog_data;
            m_vld = 0;
            if (ifa.start) begin running = 1; next_addr = 0; m_halt = 0; end
         end else if (!ifa.hold) begin
            if (ifa.jump_valid) begin
               next_addr = int'(ifa.jump_target);
               m_vld = 0;
            end else begin
               m_instr = mem_a[next_addr];
               m_ipc = next_addr;
               m_vld = 1;
               if (next_addr == LAST) begin running = 0; m_halt = 1; end
               else next_addr = (next_addr + 1) % 32;
            end
         end
         tick();
         exp = {m_instr, AW'(m_ipc), m_vld, m_halt};
         n_checks++;
         if (obs_a !== exp) begin n_fail++; $display("FAIL random[%0d]: got %h expected %h", c, obs_a, exp); end
      end
      idle_inputs();
   endtask

   initial begin
      reset = 1;
      idle_inputs();
      test_reset();
      test_sequential();
      test_hold();
      test_jump();
      test_prog_we();
      test_reset_midrun();
      test_wrap();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Parametrised instruction fetch unit: a writable program memory, a program counter with stall, jump and halt support, and a registered instruction output with a valid flag. It sits at the front of the processor datapath, feeding the decoder one instruction per cycle. Reset returns control state to idle without erasing the loaded program.

## Interface
- INSTR_W, 20: instruction width in bits.
- ADDR_W, 5: address width; memory depth is 2**ADDR_W words.
- LAST_ADDR, 24: address of the final instruction; fetching it ends the run.
- clk  in  1  clock.
- reset  in  1  reset, synchronous, active-high.
- start  in  1  pulse; begins a run from address 0 when in IDLE or HALT.
- hold  in  1  stall; freezes pc and all outputs.
- jump_valid  in  1  redirect the fetch to jump_target.
- jump_target  in  ADDR_W  jump destination.
- prog_we  in  1  program-memory write enable.
- prog_addr  in  ADDR_W  write address.
- prog_data  in  INSTR_W  write data.
- instruction  out  INSTR_W  registered fetched instruction.
- instr_pc  out  ADDR_W  address that `instruction` was fetched from.
- instr_valid  out  1  `instruction` is new this cycle.
- halted  out  1  high in the HALT state.

## Operation
- States:
  - IDLE (after reset).
  - RUN.
  - HALT.
- Memory: 2**ADDR_W x INSTR_W, not cleared by reset.
- Writes: `prog_we` is honoured only in IDLE or HALT. In RUN it is ignored, with no effect on memory.
- `start` in IDLE or HALT:
  - state goes to RUN, pc to 0, `halted` to 0.
  - `start` in RUN is ignored.
- RUN, `hold`=1: pc, state, `instruction`, `instr_pc` and `instr_valid` all hold their values. `jump_valid` is ignored, so the requester keeps it asserted until `hold` drops.
- RUN, `hold`=0, `jump_valid`=1:
  - pc gets `jump_target`.
  - `instr_valid` goes to 0; `instruction` and `instr_pc` keep their values.
  - The squashed fetch never triggers a halt, even when pc==LAST_ADDR.
- RUN, `hold`=0, `jump_valid`=0 (normal fetch):
  - `instruction` gets mem[pc], `instr_pc` gets pc, `instr_valid` goes to 1.
  - If pc==LAST_ADDR: state goes to HALT, `halted` to 1, pc holds.
  - Otherwise pc increments by 1, wrapping from 2**ADDR_W-1 to 0.
- HALT: `instr_valid` is 0; `instruction` and `instr_pc` hold the last fetched values.
- Jumps to a target above LAST_ADDR are legal. The pc runs on, wraps, and halts on reaching LAST_ADDR.
- Reset values:
  - state IDLE, pc 0.
  - `instruction` 0, `instr_pc` 0, `instr_valid` 0, `halted` 0.
- Reset has priority over every other input, including mid-run. Memory contents are preserved across reset.

## Timing
- All state changes on the rising edge of `clk`. No combinational path from any input to any output.
- Start latency:
  - `start` sampled at edge E0: RUN from E0.
  - mem[0] appears with `instr_valid`=1 after edge E1.
  - Then one instruction per unstalled cycle.
- Program write and `start` in the same cycle: the write lands at E0, so the first fetch at E1 sees the new data.
- Jump sampled at edge Ej: bubble (`instr_valid`=0) after Ej; mem[jump_target] valid after Ej+1.
- Halt: the edge that fetches LAST_ADDR sets `instr_valid`=1 and `halted`=1 together. `instr_valid` drops at the next edge.
- `hold` released: fetching resumes at the next edge with the held pc. Nothing is lost or duplicated.
- Peak throughput is 1 instruction/cycle. A run of N sequential instructions with no stalls takes N+1 cycles after `start`.

## Test plan
- Load mem[k]=k+100 for k=0..24, pulse `start`, LAST_ADDR=24 -> `instruction` 100..124 on 25 consecutive valid cycles with `instr_pc` 0..24. `halted`=1 with 124; `instr_valid`=0 afterwards.
- Hold for 3 cycles after instruction 105 -> 105 held with `instr_valid` frozen at 1. Then 106 follows with no gap or repeat.
- `jump_valid`=1, `jump_target`=20 while pc=8 -> one bubble cycle, then 120, 121, … 124, halt.
- `prog_we` during RUN writing address 3 with 0xABCDE -> mem[3] unchanged, still 103 on the next run. The same write in HALT followed by `start` -> 0xABCDE appears at `instr_pc`=3.
- Reset asserted mid-run at pc=12 -> next cycle all outputs 0, state IDLE. `start` then replays 100.. from address 0, proving the memory is retained.
- ADDR_W=3, LAST_ADDR=2, jump to 6 -> fetches 6, 7, 0, 1, 2 (wrap from 7 to 0), then halt.
